// File: rtl/fifo_stim_driver_if.sv
// FIFO write/read-side bundle shared by the stimulus driver and the FIFO.
// master drives data and requests; slave returns the status flags.
interface fifo_stim_driver_if #(
  parameter int W = 16
) ();
  logic [W-1:0] data_in;
  logic         wr_en;
  logic         rd_en;
  logic         full;
  logic         empty;
  logic         wr_ack;
  logic         overflow;
  logic         underflow;

  modport master (
    output data_in, wr_en, rd_en,
    input  full, empty, wr_ack, overflow, underflow
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output full, empty, wr_ack, overflow, underflow
  );
endinterface

// File: rtl/fifo_stim_driver.sv
// FIFO stimulus engine: fill, overflow probe, drain, underflow probe, mixed.
// LFSR write data and saturating event counters for self-test comparison.
module fifo_stim_driver #(
  parameter int          FIFO_WIDTH   = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          MIXED_CYCLES = 64,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  fifo_stim_driver_if.master bus,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] wr_count,
  output logic [15:0] ack_count,
  output logic [15:0] ovf_count,
  output logic [15:0] udf_count
);

  localparam logic [15:0] TMO_LAST = 16'(4 * FIFO_DEPTH - 1);
  localparam logic [7:0]  CYC_LAST = 8'(MIXED_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_OVER, S_DRAIN, S_UNDER, S_MIXED, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cyc_q, cyc_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] lfsr_q, lfsr_nx;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        clr;
  logic [15:0] wcnt_q, acnt_q, ocnt_q, ucnt_q;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v,
    input logic        ev
  );
    return (ev && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  assign lfsr_nx = {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Outputs are registered decodes of the current state.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    clr     = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    busy_d  = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          err_d   = 1'b0;
          tmo_d   = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        wr_d  = 1'b1;
        tmo_d = tmo_q + 16'd1;
        if (bus.full) begin
          state_d = S_OVER;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_OVER: begin
        wr_d    = 1'b1;
        tmo_d   = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        rd_d  = 1'b1;
        tmo_d = tmo_q + 16'd1;
        if (bus.empty) begin
          state_d = S_UNDER;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_UNDER;
        end
      end
      S_UNDER: begin
        rd_d    = 1'b1;
        cyc_d   = '0;
        state_d = S_MIXED;
      end
      S_MIXED: begin
        wr_d  = (cyc_q[1:0] != 2'b11);
        rd_d  = (cyc_q[1:0] != 2'b00);
        cyc_d = cyc_q + 8'd1;
        if (cyc_q == CYC_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      tmo_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
      acnt_q  <= '0;
      ocnt_q  <= '0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      tmo_q   <= tmo_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (clr)       lfsr_q <= LFSR_SEED;
      else if (wr_q) lfsr_q <= lfsr_nx;
      if (clr) begin
        wcnt_q <= '0;
        acnt_q <= '0;
        ocnt_q <= '0;
        ucnt_q <= '0;
      end else if (busy_q) begin
        wcnt_q <= sat_inc(wcnt_q, wr_q);
        acnt_q <= sat_inc(acnt_q, bus.wr_ack);
        ocnt_q <= sat_inc(ocnt_q, bus.overflow);
        ucnt_q <= sat_inc(ucnt_q, bus.underflow);
      end
    end
  end

  assign bus.data_in = lfsr_q[FIFO_WIDTH-1:0];
  assign bus.wr_en   = wr_q;
  assign bus.rd_en   = rd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = err_q;
  assign wr_count    = wcnt_q;
  assign ack_count   = acnt_q;
  assign ovf_count   = ocnt_q;
  assign udf_count   = ucnt_q;

endmodule
